// File: rtl/command_packet_receiver_pkg.sv
// Shared definitions for the command packet receiver and the command reader
// controller: opcode nibbles, drop reason codes, receiver state encoding.
package command_packet_receiver_pkg;

  // Opcode classes, decoded on the upper nibble of the opcode byte
  localparam logic [3:0] OP_SET_FREQ    = 4'hF;
  localparam logic [3:0] OP_SET_THRESH  = 4'h7;
  localparam logic [3:0] OP_SEND_MAX    = 4'h4;
  localparam logic [3:0] OP_TRIG_DETECT = 4'hD;

  // Drop reasons reported on err_code
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_UNKNOWN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  // Receiver state encoding
  localparam logic [1:0] ST_WAIT_OP = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;

  typedef enum logic [1:0] {
    OPC_UNKNOWN = 2'd0,
    OPC_ZERO    = 2'd1,
    OPC_TWO     = 2'd2
  } opc_class_e;

  // Number of operand bytes that follow an opcode, as a class
  function automatic opc_class_e opc_class(input logic [3:0] nib);
    opc_class_e cls;
    case (nib)
      OP_SET_FREQ, OP_SET_THRESH:  cls = OPC_TWO;
      OP_SEND_MAX, OP_TRIG_DETECT: cls = OPC_ZERO;
      default:                     cls = OPC_UNKNOWN;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/command_packet_receiver_timeout.sv
// Inter-byte timeout counter: loadable up-counter with clear and enable.
// tc flags that the next enabled cycle is the BYTE_TIMEOUT-th silent cycle.
module cmd_byte_timeout #(
  parameter int BYTE_TIMEOUT = 100000,
  parameter int TO_W         = 17
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            clr,
  input  logic            load,
  input  logic [TO_W-1:0] load_val,
  input  logic            en,
  output logic            tc
);

  localparam logic [TO_W-1:0] TC_VAL = TO_W'(BYTE_TIMEOUT - 1);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  // Next count: clear beats load beats increment; saturate at the terminal value
  always_comb begin
    if (clr) begin
      count_d = {TO_W{1'b0}};
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != TC_VAL)) begin
      count_d = count_q + TO_W'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      count_q <= {TO_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/command_packet_receiver.sv
// Command packet receiver: assembles UART bytes into opcode + operand
// packets, spaces committed packets by MIN_GAP cycles, reports drops.
module command_packet_receiver
  import command_packet_receiver_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 100000,
  parameter int MIN_GAP      = 4,
  parameter int TO_W         = 17
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  Command,
  output logic [15:0] Operand,
  output logic        Rx_Ready,
  output logic        cmd_error,
  output logic [1:0]  err_code
);

  localparam int GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1'b1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       shadow_cmd_q, shadow_cmd_d;
  logic [15:0]      shadow_opnd_q, shadow_opnd_d;
  logic             done_q, done_d;
  logic             pend_q, pend_d;
  logic [7:0]       pend_cmd_q, pend_cmd_d;
  logic [15:0]      pend_opnd_q, pend_opnd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       command_q, command_d;
  logic [15:0]      operand_q, operand_d;
  logic             rx_ready_q, rx_ready_d;
  logic             cmd_error_q, cmd_error_d;
  logic [1:0]       err_code_q, err_code_d;

  opc_class_e op_cls_s;
  logic       to_clr_s;
  logic       to_en_s;
  logic       to_tc_s;
  logic       unknown_s;
  logic       expire_s;
  logic       overrun_s;

  assign op_cls_s = opc_class(rx_data[7:4]);

  cmd_byte_timeout #(
    .BYTE_TIMEOUT(BYTE_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk     (clk),
    .reset_b (reset_b),
    .clr     (to_clr_s),
    .load    (1'b0),
    .load_val({TO_W{1'b0}}),
    .en      (to_en_s),
    .tc      (to_tc_s)
  );

  // Byte assembly: walk opcode/high/low bytes into the shadow register
  always_comb begin
    state_d       = state_q;
    shadow_cmd_d  = shadow_cmd_q;
    shadow_opnd_d = shadow_opnd_q;
    done_d        = 1'b0;
    to_clr_s      = 1'b0;
    to_en_s       = 1'b0;
    unknown_s     = 1'b0;
    expire_s      = 1'b0;
    case (state_q)
      ST_WAIT_OP: begin
        to_clr_s = 1'b1;
        if (rx_valid) begin
          case (op_cls_s)
            OPC_ZERO: begin
              shadow_cmd_d  = rx_data;
              shadow_opnd_d = 16'h0000;
              done_d        = 1'b1;
            end
            OPC_TWO: begin
              shadow_cmd_d = rx_data;
              state_d      = ST_WAIT_HI;
            end
            default: begin
              unknown_s = 1'b1;
            end
          endcase
        end else begin
          state_d = ST_WAIT_OP;
        end
      end
      ST_WAIT_HI, ST_WAIT_LO: begin
        if (rx_valid) begin
          // A byte in the expiry cycle is still accepted
          to_clr_s = 1'b1;
          if (state_q == ST_WAIT_HI) begin
            shadow_opnd_d[15:8] = rx_data;
            state_d             = ST_WAIT_LO;
          end else begin
            shadow_opnd_d[7:0] = rx_data;
            done_d             = 1'b1;
            state_d            = ST_WAIT_OP;
          end
        end else begin
          to_en_s = 1'b1;
          if (to_tc_s) begin
            expire_s = 1'b1;
            state_d  = ST_WAIT_OP;
          end else begin
            state_d = state_q;
          end
        end
      end
      default: begin
        state_d = ST_WAIT_OP;
      end
    endcase
  end

  // Commit, deferral, overrun and error reporting for completed packets
  always_comb begin
    pend_d      = pend_q;
    pend_cmd_d  = pend_cmd_q;
    pend_opnd_d = pend_opnd_q;
    command_d   = command_q;
    operand_d   = operand_q;
    rx_ready_d  = 1'b0;
    err_code_d  = err_code_q;
    overrun_s   = done_q && pend_q;

    if (done_q && !pend_q && (gap_q == GAP_ZERO)) begin
      command_d  = shadow_cmd_q;
      operand_d  = shadow_opnd_q;
      rx_ready_d = 1'b1;
    end else if (pend_q && (gap_q == GAP_ZERO)) begin
      command_d  = pend_cmd_q;
      operand_d  = pend_opnd_q;
      rx_ready_d = 1'b1;
      pend_d     = 1'b0;
    end else if (done_q && !pend_q) begin
      pend_d      = 1'b1;
      pend_cmd_d  = shadow_cmd_q;
      pend_opnd_d = shadow_opnd_q;
    end else begin
      pend_d = pend_q;
    end

    if (rx_ready_d) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != GAP_ZERO) begin
      gap_d = gap_q - GAP_ONE;
    end else begin
      gap_d = gap_q;
    end

    // An overrun outranks a simultaneous unknown opcode or timeout
    cmd_error_d = overrun_s || expire_s || unknown_s;
    if (overrun_s) begin
      err_code_d = ERR_OVERRUN;
    end else if (expire_s) begin
      err_code_d = ERR_TIMEOUT;
    end else if (unknown_s) begin
      err_code_d = ERR_UNKNOWN;
    end else begin
      err_code_d = err_code_q;
    end
  end

  // State and output registers; reset drops any partial or pending packet
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q       <= ST_WAIT_OP;
      shadow_cmd_q  <= 8'h00;
      shadow_opnd_q <= 16'h0000;
      done_q        <= 1'b0;
      pend_q        <= 1'b0;
      pend_cmd_q    <= 8'h00;
      pend_opnd_q   <= 16'h0000;
      gap_q         <= GAP_ZERO;
      command_q     <= 8'h00;
      operand_q     <= 16'h0000;
      rx_ready_q    <= 1'b0;
      cmd_error_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      shadow_cmd_q  <= shadow_cmd_d;
      shadow_opnd_q <= shadow_opnd_d;
      done_q        <= done_d;
      pend_q        <= pend_d;
      pend_cmd_q    <= pend_cmd_d;
      pend_opnd_q   <= pend_opnd_d;
      gap_q         <= gap_d;
      command_q     <= command_d;
      operand_q     <= operand_d;
      rx_ready_q    <= rx_ready_d;
      cmd_error_q   <= cmd_error_d;
      err_code_q    <= err_code_d;
    end
  end

  assign Command   = command_q;
  assign Operand   = operand_q;
  assign Rx_Ready  = rx_ready_q;
  assign cmd_error = cmd_error_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_command_packet_receiver.sv
// Bench for command_packet_receiver: directed vector table, timeout-boundary
// sequences and randomized traffic checked against a packet-level model.
module tb_command_packet_receiver;
  import command_packet_receiver_pkg::*;

  localparam int BT   = 64;
  localparam int MG   = 4;
  localparam int TW   = 7;
  localparam int NCYC = 8192;

  logic        clk      = 1'b0;
  logic        reset_b  = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic [7:0]  Command;
  logic [15:0] Operand;
  logic        Rx_Ready;
  logic        cmd_error;
  logic [1:0]  err_code;

  command_packet_receiver #(
    .BYTE_TIMEOUT(BT),
    .MIN_GAP     (MG),
    .TO_W        (TW)
  ) dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .Command  (Command),
    .Operand  (Operand),
    .Rx_Ready (Rx_Ready),
    .cmd_error(cmd_error),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: per-cycle event timeline of expected pulses
  bit          ev_rdy [NCYC];
  logic [7:0]  ev_cmd [NCYC];
  logic [15:0] ev_op  [NCYC];
  bit          ev_err [NCYC];
  logic [1:0]  ev_code[NCYC];
  bit          ev_rst [NCYC];
  logic [7:0]  pkt[$];
  int          idle       = 0;
  int          last_ready = -1000;
  int          defer_r    = -1;
  logic        m_rdy  = 1'b0;
  logic        m_err  = 1'b0;
  logic [1:0]  m_code = 2'b00;
  logic [7:0]  m_cmd  = 8'h00;
  logic [15:0] m_op   = 16'h0000;

  function automatic int ops_for(input logic [7:0] op);
    if (op[7:4] == OP_SET_FREQ || op[7:4] == OP_SET_THRESH) return 2;
    else if (op[7:4] == OP_SEND_MAX || op[7:4] == OP_TRIG_DETECT) return 0;
    else return -1;
  endfunction

  function automatic void post_err(input int c, input logic [1:0] code);
    if (c < NCYC) begin
      if (!ev_err[c] || code == 2'b11) ev_code[c] = code;
      ev_err[c] = 1'b1;
    end
  endfunction

  function automatic void post_rdy(input int c, input logic [7:0] cm, input logic [15:0] op);
    if (c < NCYC) begin
      ev_rdy[c] = 1'b1;
      ev_cmd[c] = cm;
      ev_op[c]  = op;
    end
  endfunction

  // Packet completed by the byte of cycle t: publish, defer or drop
  function automatic void packet_done(input int t, input logic [7:0] cm, input logic [15:0] op);
    int d;
    d = t + 1;
    if (defer_r > d) begin
      post_err(d + 1, 2'b11);
    end else if (d + 1 >= last_ready + MG) begin
      post_rdy(d + 1, cm, op);
      last_ready = d + 1;
    end else begin
      last_ready = last_ready + MG;
      defer_r    = last_ready;
      post_rdy(last_ready, cm, op);
    end
  endfunction

  function automatic void model_step(input int t, input bit rstb, input bit vld, input logic [7:0] d);
    if (!rstb) begin
      for (int k = t + 1; k <= t + MG + 4 && k < NCYC; k++) begin
        ev_rdy[k] = 1'b0;
        ev_err[k] = 1'b0;
      end
      if (t + 1 < NCYC) ev_rst[t + 1] = 1'b1;
      pkt.delete();
      idle       = 0;
      last_ready = -1000;
      defer_r    = -1;
    end else if (pkt.size() == 0) begin
      if (vld) begin
        case (ops_for(d))
          0:       packet_done(t, d, 16'h0000);
          2:       begin pkt.push_back(d); idle = 0; end
          default: post_err(t + 1, 2'b01);
        endcase
      end
    end else if (vld) begin
      pkt.push_back(d);
      idle = 0;
      if (pkt.size() == 3) begin
        packet_done(t, pkt[0], {pkt[1], pkt[2]});
        pkt.delete();
      end
    end else begin
      idle++;
      if (idle == BT) begin
        post_err(t + 1, 2'b10);
        pkt.delete();
        idle = 0;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, advance model, sample after the edge, compare
  task automatic tick(input bit rstb, input bit vld, input logic [7:0] d);
    reset_b  = rstb;
    rx_valid = vld;
    rx_data  = d;
    model_step(cyc, rstb, vld, d);
    @(posedge clk);
    #1;
    cyc++;
    if (ev_rst[cyc]) begin
      m_rdy = 1'b0; m_err = 1'b0; m_code = 2'b00; m_cmd = 8'h00; m_op = 16'h0000;
    end else begin
      m_rdy = ev_rdy[cyc];
      m_err = ev_err[cyc];
      if (m_rdy) begin m_cmd = ev_cmd[cyc]; m_op = ev_op[cyc]; end
      if (m_err) m_code = ev_code[cyc];
    end
    check("model_rdy",  32'(Rx_Ready),  32'(m_rdy));
    check("model_err",  32'(cmd_error), 32'(m_err));
    check("model_code", 32'(err_code),  32'(m_code));
    check("model_cmd",  32'(Command),   32'(m_cmd));
    check("model_opnd", 32'(Operand),   32'(m_op));
  endtask

  typedef struct {
    bit          rstb;
    bit          vld;
    logic [7:0]  d;
    int          rep;
    bit          rdy;
    bit          err;
    logic [1:0]  code;
    logic [7:0]  cmd;
    logic [15:0] opnd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit rstb, input bit vld, input logic [7:0] d, input int rep,
                              input bit rdy, input bit err, input logic [1:0] code,
                              input logic [7:0] cmd, input logic [15:0] opnd);
    vec_t v;
    v.rstb = rstb; v.vld = vld; v.d = d; v.rep = rep;
    v.rdy = rdy; v.err = err; v.code = code; v.cmd = cmd; v.opnd = opnd;
    tbl.push_back(v);
  endfunction

  initial begin
    // Expectations describe outputs seen after the edge closing each cycle
    add(1'b0, 1'b0, 8'h00,  2, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
    add(1'b1, 1'b1, 8'hF2,  1, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 8'h00, 49, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
    add(1'b1, 1'b1, 8'h12,  1, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 8'h00, 49, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
    add(1'b1, 1'b1, 8'h34,  1, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 8'h00,  1, 1'b1, 1'b0, 2'b00, 8'hF2, 16'h1234);
    add(1'b1, 1'b0, 8'h00,  3, 1'b0, 1'b0, 2'b00, 8'hF2, 16'h1234);
    add(1'b1, 1'b1, 8'h41,  1, 1'b0, 1'b0, 2'b00, 8'hF2, 16'h1234);
    add(1'b1, 1'b0, 8'h00,  1, 1'b1, 1'b0, 2'b00, 8'h41, 16'h0000);
    add(1'b1, 1'b0, 8'h00,  4, 1'b0, 1'b0, 2'b00, 8'h41, 16'h0000);
    add(1'b1, 1'b1, 8'h25,  1, 1'b0, 1'b1, 2'b01, 8'h41, 16'h0000);
    add(1'b1, 1'b0, 8'h00,  4, 1'b0, 1'b0, 2'b01, 8'h41, 16'h0000);
    add(1'b1, 1'b1, 8'h70,  1, 1'b0, 1'b0, 2'b01, 8'h41, 16'h0000);
    add(1'b1, 1'b1, 8'hAB,  1, 1'b0, 1'b0, 2'b01, 8'h41, 16'h0000);
    add(1'b1, 1'b0, 8'h00, BT - 1, 1'b0, 1'b0, 2'b01, 8'h41, 16'h0000);
    add(1'b1, 1'b0, 8'h00,  1, 1'b0, 1'b1, 2'b10, 8'h41, 16'h0000);
    add(1'b1, 1'b0, 8'h00,  2, 1'b0, 1'b0, 2'b10, 8'h41, 16'h0000);
    add(1'b1, 1'b1, 8'hD0,  1, 1'b0, 1'b0, 2'b10, 8'h41, 16'h0000);
    add(1'b1, 1'b0, 8'h00,  1, 1'b1, 1'b0, 2'b10, 8'hD0, 16'h0000);
    add(1'b1, 1'b0, 8'h00,  4, 1'b0, 1'b0, 2'b10, 8'hD0, 16'h0000);
    add(1'b1, 1'b1, 8'h41,  1, 1'b0, 1'b0, 2'b10, 8'hD0, 16'h0000);
    add(1'b1, 1'b1, 8'hD0,  1, 1'b1, 1'b0, 2'b10, 8'h41, 16'h0000);
    add(1'b1, 1'b1, 8'h40,  1, 1'b0, 1'b0, 2'b10, 8'h41, 16'h0000);
    add(1'b1, 1'b0, 8'h00,  1, 1'b0, 1'b1, 2'b11, 8'h41, 16'h0000);
    add(1'b1, 1'b0, 8'h00,  1, 1'b0, 1'b0, 2'b11, 8'h41, 16'h0000);
    add(1'b1, 1'b0, 8'h00,  1, 1'b1, 1'b0, 2'b11, 8'hD0, 16'h0000);
    add(1'b1, 1'b0, 8'h00,  4, 1'b0, 1'b0, 2'b11, 8'hD0, 16'h0000);
    add(1'b1, 1'b1, 8'hF0,  1, 1'b0, 1'b0, 2'b11, 8'hD0, 16'h0000);
    add(1'b1, 1'b1, 8'h01,  1, 1'b0, 1'b0, 2'b11, 8'hD0, 16'h0000);
    add(1'b0, 1'b0, 8'h00,  1, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
    add(1'b1, 1'b1, 8'h00,  1, 1'b0, 1'b1, 2'b01, 8'h00, 16'h0000);
    add(1'b1, 1'b1, 8'h02,  1, 1'b0, 1'b1, 2'b01, 8'h00, 16'h0000);
    add(1'b1, 1'b0, 8'h00,  6, 1'b0, 1'b0, 2'b01, 8'h00, 16'h0000);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        tick(tbl[i].rstb, tbl[i].vld, tbl[i].d);
        check($sformatf("vec%0d_rdy", i),  32'(Rx_Ready),  32'(tbl[i].rdy));
        check($sformatf("vec%0d_err", i),  32'(cmd_error), 32'(tbl[i].err));
        check($sformatf("vec%0d_code", i), 32'(err_code),  32'(tbl[i].code));
        check($sformatf("vec%0d_cmd", i),  32'(Command),   32'(tbl[i].cmd));
        check($sformatf("vec%0d_opnd", i), 32'(Operand),   32'(tbl[i].opnd));
      end
    end

    // Last operand byte arrives in the very cycle the timeout would expire
    tick(1'b1, 1'b1, 8'hF1);
    tick(1'b1, 1'b1, 8'h22);
    for (int k = 0; k < BT - 1; k++) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h33);
    check("edge_no_err", 32'(cmd_error), 32'(1'b0));
    tick(1'b1, 1'b0, 8'h00);
    check("edge_rdy",  32'(Rx_Ready), 32'(1'b1));
    check("edge_cmd",  32'(Command),  32'(8'hF1));
    check("edge_opnd", 32'(Operand),  32'(16'h2233));

    // One cycle later the packet is abandoned and the late byte is an opcode
    for (int k = 0; k < MG; k++) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'hF1);
    tick(1'b1, 1'b1, 8'h22);
    for (int k = 0; k < BT; k++) tick(1'b1, 1'b0, 8'h00);
    check("late_to_err",  32'(cmd_error), 32'(1'b1));
    check("late_to_code", 32'(err_code),  32'(2'b10));
    tick(1'b1, 1'b1, 8'h33);
    check("late_unk_err",  32'(cmd_error), 32'(1'b1));
    check("late_unk_code", 32'(err_code),  32'(2'b01));
    check("late_cmd_held", 32'(Command),   32'(8'hF1));

    // Randomized traffic in segments of differing byte density
    for (int seg = 0; seg < 20; seg++) begin
      int p;
      case ($urandom_range(0, 2))
        0:       p = 50;
        1:       p = 10;
        default: p = 1;
      endcase
      for (int k = 0; k < 200; k++) begin
        bit         rstb;
        bit         vld;
        logic [7:0] d;
        logic [3:0] nibs [4];
        nibs[0] = OP_SET_FREQ; nibs[1] = OP_SET_THRESH;
        nibs[2] = OP_SEND_MAX; nibs[3] = OP_TRIG_DETECT;
        rstb = ($urandom_range(0, 299) != 0);
        vld  = ($urandom_range(0, 99) < p);
        d    = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) d[7:4] = nibs[$urandom_range(0, 3)];
        tick(rstb, vld, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/command_packet_receiver.md
Name: command_packet_receiver

Overview:
- Upstream stage of the command reader controller.
- Assembles UART receive bytes into complete command packets: one opcode byte, then 0 or 2 operand bytes depending on the opcode.
- Presents Command[7:0] and Operand[15:0], and pulses Rx_Ready for one cycle per valid packet.
- Drops malformed or stalled packets and reports them on cmd_error.

Parameters:
- BYTE_TIMEOUT, 100000: max clk cycles between operand bytes of one packet before the packet is abandoned.
- MIN_GAP, 4: min clk cycles between consecutive Rx_Ready pulses, so the controller can leave INTERPERET_OP and return to IDLE.
- TO_W, 17: width of the inter-byte timeout counter; must satisfy 2^TO_W > BYTE_TIMEOUT.

Ports:
- clk  in  1  system clock
- reset_b  in  1  synchronous, active-low reset
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- Command  out  8  opcode of last committed packet
- Operand  out  16  operand of last committed packet, big-endian (first operand byte = [15:8])
- Rx_Ready  out  1  one-cycle pulse: Command/Operand newly committed
- cmd_error  out  1  one-cycle pulse: packet dropped
- err_code  out  2  reason of last drop: 01 unknown opcode, 10 timeout, 11 overrun; 00 after reset

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_b; it is sampled on posedge clk only.
- Reset values: Command=8'h00, Operand=16'h0000, Rx_Ready=0, cmd_error=0, err_code=00, state=WAIT_OP, pending=0, gap counter=0, timeout counter=0. Reset mid-packet discards all partial data with no error pulse.
- Opcode classes (on rx_data[7:4]):
  - 4'hF (set frequency): 2 operand bytes.
  - 4'h7 (set threshold): 2 operand bytes.
  - 4'h4 (send max): 0 operand bytes.
  - 4'hD (trigger detect): 0 operand bytes.
  - Any other value: unknown.
- State machine:
  - WAIT_OP, rx_valid:
    - Unknown opcode: stay in WAIT_OP; next cycle cmd_error=1, err_code=01.
    - 0-operand opcode: latch opcode into the shadow register; complete the packet.
    - 2-operand opcode: latch opcode; go to WAIT_HI; clear the timeout counter.
  - WAIT_HI, rx_valid: latch byte into shadow[15:8]; go to WAIT_LO; clear the timeout counter.
  - WAIT_LO, rx_valid: latch byte into shadow[7:0]; complete the packet; go to WAIT_OP.
  - WAIT_HI/WAIT_LO, no rx_valid: increment the timeout counter. When it reaches BYTE_TIMEOUT, go to WAIT_OP; next cycle cmd_error=1, err_code=10. rx_valid in the same cycle as expiry wins: the byte is accepted and there is no timeout.
- Completion:
  - If the gap counter is 0 and pending=0: on the next edge, Command/Operand are updated from the shadow register and Rx_Ready=1 for exactly one cycle. Latency is 1 cycle from the accepting edge of the final byte to the Rx_Ready high cycle.
  - Operand is 16'h0000 for 0-operand opcodes.
  - Otherwise set pending=1 and commit when the gap counter reaches 0.
- Gap counter: loaded with MIN_GAP-1 on each Rx_Ready pulse; decrements to 0.
- Outputs are stable between commits: Command/Operand change only in the Rx_Ready cycle and are held until the next commit.
- Overrun: a packet completing while pending=1 is dropped; the pending packet is kept; cmd_error=1, err_code=11.
- New bytes are accepted during pending; only commits are deferred.
- Error pulses coincide with no Rx_Ready. If an error and a deferred commit fall in the same cycle, both pulse; err_code is updated, and Command/Operand are unaffected by the error.

Decomposition:
- Shared package holds:
  - opcode nibble constants: OP_SET_FREQ=4'hF, OP_SET_THRESH=4'h7, OP_SEND_MAX=4'h4, OP_TRIG_DETECT=4'hD;
  - err_code constants: ERR_NONE, ERR_UNKNOWN, ERR_TIMEOUT, ERR_OVERRUN;
  - state encoding.
- These opcode constants are the same ones the controller decodes.
- One sub-module: cmd_byte_timeout, a loadable up-counter with clear, enable and terminal-count output, parameterised by BYTE_TIMEOUT and TO_W.

Test Plan:
- Bytes 0xF2, 0x12, 0x34 spaced 50 cycles -> one cycle after 0x34 is accepted: Rx_Ready=1, Command=0xF2, Operand=0x1234; held afterwards.
- Byte 0x41 -> Rx_Ready 1 cycle later, Command=0x41, Operand=0x0000; no cmd_error.
- Byte 0x25 -> cmd_error pulse, err_code=01, no Rx_Ready, Command unchanged.
- Bytes 0x70, 0xAB then silence for BYTE_TIMEOUT cycles -> cmd_error, err_code=10. Following 0xD0 -> Rx_Ready, Command=0xD0, Operand=0x0000.
- 0x41 then 0xD0 on consecutive cycles -> second Rx_Ready exactly MIN_GAP cycles after the first. A third 0x40 arriving while 0xD0 is pending -> cmd_error, err_code=11, Command ends as 0xD0.
- reset_b low for 1 cycle after 0xF0, 0x01 -> no Rx_Ready or error. Then 0x00, 0x02 -> 0x00 is rejected as unknown (err_code=01); 0x02 is rejected as unknown; Command/Operand remain 0x00/0x0000.
